uart_tx_param: RTL and testbench

Parametrised UART transmitter with a small input FIFO. It generalises the button-triggered single-byte transmitter: configurable data width, parity and stop bits, an integer baud divider derived from parameters, and a valid/ready byte interface so upstream logic can queue several words. It sits between user/control logic (button one-shots, display or memory readers) and the board's serial `tx` pin.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_fifo.sv | 47 ++++
 rtl/uart_tx_param.sv | 157 +++++++++++++++
 tb/tb_uart_tx_param.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART transmitter.
package uart_pkg;

  // Transmitter FSM states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  // Parity modes selected by the PARITY parameter.
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Clock cycles per bit; truncating integer division.
  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO. Pointers carry one extra wrap bit so that
// full and empty can be told apart when the address bits match.
// The read port is combinational so a pop can load the frame shifter
// on the same edge that the FSM decides to start a frame.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;

  // Pointer update; both may move on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since empty gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr_reg[AW-1:0]];
  assign count   = wr_ptr_reg - rd_ptr_reg;
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: valid/ready input queue feeding a
// start/data/parity/stop frame FSM with an integer baud divider.
// Consecutive queued words are sent with no idle time between frames.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int DIV    = calc_div(CLK_HZ, BAUD);
  localparam int BAUD_W = $clog2(DIV);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(DIV - 1);
  localparam logic [BIT_W-1:0]  LAST_DATA   = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  LAST_STOP   = BIT_W'(STOP_BITS - 1);

  uart_state_t           state_reg, state_next;
  logic [BAUD_W-1:0]     baud_reg, baud_next;
  logic [BIT_W-1:0]      bit_reg, bit_next;
  logic [DATA_BITS-1:0]  shift_reg, shift_next;
  logic                  par_reg, par_next;
  logic                  tx_reg, tx_next;

  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_BITS-1:0]  fifo_rd_data;
  logic                  baud_tick, start_frame;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (fifo_push),
    .wr_data (tx_data),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign fifo_push = tx_valid & ~fifo_full;
  assign tx_ready  = ~fifo_full;
  assign baud_tick = (baud_reg == '0);
  assign tx        = tx_reg;
  assign busy      = (state_reg != ST_IDLE) || !fifo_empty;

  // Frame sequencing: next state, line level and datapath updates.
  always_comb begin
    state_next  = state_reg;
    baud_next   = baud_tick ? BAUD_RELOAD : baud_reg - BAUD_W'(1);
    bit_next    = bit_reg;
    shift_next  = shift_reg;
    par_next    = par_reg;
    tx_next     = tx_reg;
    fifo_pop    = 1'b0;
    start_frame = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        tx_next   = 1'b1;
        baud_next = BAUD_RELOAD;
        if (!fifo_empty) start_frame = 1'b1;
      end
      ST_START: begin
        if (baud_tick) begin
          state_next = ST_DATA;
          bit_next   = '0;
          tx_next    = shift_reg[0];
          par_next   = par_reg ^ shift_reg[0];
          shift_next = shift_reg >> 1;
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          if (bit_reg == LAST_DATA) begin
            if (PARITY != PAR_NONE) begin
              state_next = ST_PARITY;
              tx_next    = (PARITY == PAR_ODD) ? ~par_reg : par_reg;
            end else begin
              state_next = ST_STOP;
              tx_next    = 1'b1;
              bit_next   = '0;
            end
          end else begin
            bit_next   = bit_reg + BIT_W'(1);
            tx_next    = shift_reg[0];
            par_next   = par_reg ^ shift_reg[0];
            shift_next = shift_reg >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (baud_tick) begin
          state_next = ST_STOP;
          tx_next    = 1'b1;
          bit_next   = '0;
        end
      end
      ST_STOP: begin
        if (baud_tick) begin
          if (bit_reg == LAST_STOP) begin
            if (!fifo_empty) start_frame = 1'b1;
            else             state_next  = ST_IDLE;
          end else begin
            bit_next = bit_reg + BIT_W'(1);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Pop the next word and drive the start bit on the same edge.
    if (start_frame) begin
      fifo_pop   = 1'b1;
      shift_next = fifo_rd_data;
      par_next   = 1'b0;
      tx_next    = 1'b0;
      baud_next  = BAUD_RELOAD;
      state_next = ST_START;
    end
  end

  // State and datapath registers; reset forces the line idle at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      par_reg   <= 1'b0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      par_reg   <= par_next;
      tx_reg    <= tx_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: four frame formats side by side, each with an
// accept-side scoreboard queue and a line receiver that decodes frames.
module tb_uart_tx_param;
  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int NCFG   = 4;
  localparam int CFG_DB  [NCFG] = '{8, 8, 8, 7};
  localparam int CFG_PAR [NCFG] = '{0, 1, 2, 0};
  localparam int CFG_SB  [NCFG] = '{1, 1, 1, 2};

  typedef struct {
    logic [8:0] w;
    int         acc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] data    [NCFG];
  logic       valid   [NCFG];
  logic       ready_s [NCFG];
  logic       tx_s    [NCFG];
  logic       busy_s  [NCFG];
  logic [2:0] cnt_s   [NCFG];
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_dut
    localparam int DB  = CFG_DB[gi];
    localparam int PAR = CFG_PAR[gi];
    localparam int SB  = CFG_SB[gi];
    localparam int L   = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;
    localparam logic [8:0] MASK = 9'((1 << DB) - 1);

    logic [DB-1:0] din;
    logic          rdy, txl, bsy;
    logic [2:0]    cnt;
    exp_t          exp_q [$];
    int            last_end = 0;

    assign din         = data[gi][DB-1:0];
    assign ready_s[gi] = rdy;
    assign tx_s[gi]    = txl;
    assign busy_s[gi]  = bsy;
    assign cnt_s[gi]   = cnt;

    uart_tx_param #(
      .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(DB),
      .PARITY(PAR), .STOP_BITS(SB), .FIFO_DEPTH(4)
    ) u_dut (
      .clk(clk), .reset(rst_n), .tx_data(din), .tx_valid(valid[gi]),
      .tx_ready(rdy), .tx(txl), .busy(bsy), .fifo_count(cnt)
    );

    // Scoreboard push: a handshake seen now completes on the next edge.
    initial forever begin
      @(negedge clk);
      if (rst_n && valid[gi] && rdy) exp_q.push_back('{w: data[gi], acc: cyc + 1});
    end

    // Receiver: slices each frame into DIV-cycle bits and checks them.
    initial begin
      logic [15:0] got_v, exp_v;
      bit          abort, stable, pend_busy;
      exp_t        e;
      int          f, idx, exp_start;
      pend_busy = 0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          exp_q.delete();
          last_end  = 0;
          pend_busy = 0;
        end else begin
          if (pend_busy && exp_q.size() == 0)
            chk($sformatf("cfg%0d_busy_after_frame", gi), bsy, 0);
          pend_busy = 0;
          if (txl == 1'b0) begin
            f = cyc;
            chk($sformatf("cfg%0d_busy_in_frame", gi), bsy, 1);
            abort = 0; stable = 1; got_v = '0;
            for (int j = 0; j < L && !abort; j++) begin
              for (int k = 0; k < DIV && !abort; k++) begin
                if (j != 0 || k != 0) @(negedge clk);
                if (!rst_n) abort = 1;
                else if (k == 0) got_v[j] = txl;
                else if (txl != got_v[j]) stable = 0;
              end
            end
            if (abort) begin
              exp_q.delete();
              last_end = 0;
            end else begin
              chk($sformatf("cfg%0d_frame_expected", gi), int'(exp_q.size() > 0), 1);
              if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                exp_start = (e.acc + 1 > last_end) ? e.acc + 1 : last_end;
                exp_v = '0;
                for (int j = 0; j < DB; j++) exp_v[1+j] = e.w[j];
                idx = 1 + DB;
                if (PAR != 0) begin
                  exp_v[idx] = (^(e.w & MASK)) ^ (PAR == 2);
                  idx++;
                end
                for (int j = 0; j < SB; j++) exp_v[idx+j] = 1'b1;
                chk($sformatf("cfg%0d_start_cycle", gi), f, exp_start);
                chk($sformatf("cfg%0d_bit_stable", gi), int'(stable), 1);
                chk($sformatf("cfg%0d_frame_bits", gi), got_v, exp_v);
                $display("[TB] cfg%0d word=0x%0h start=%0d bits=0x%0h", gi, e.w & MASK, f, got_v);
              end
              last_end  = f + L * DIV;
              pend_busy = 1;
            end
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin @(posedge clk); #1; end
    @(negedge clk);
  endtask

  // Hold valid until accepted; scramble data afterwards.
  task automatic send(input int k, input logic [8:0] w);
    bit acc, done;
    done = 0;
    data[k] = w; valid[k] = 1'b1;
    for (int n = 0; n < 2000 && !done; n++) begin
      @(negedge clk); acc = ready_s[k];
      @(posedge clk); #1;
      if (acc) done = 1;
    end
    valid[k] = 1'b0;
    data[k]  = 9'($urandom);
    if (!done) chk("send_timeout", 0, 1);
  endtask

  function automatic int pending();
    return g_dut[0].exp_q.size() + g_dut[1].exp_q.size() +
           g_dut[2].exp_q.size() + g_dut[3].exp_q.size();
  endfunction

  task automatic wait_drain();
    bit ok;
    ok = 0;
    for (int n = 0; n < 5000 && !ok; n++) begin
      @(posedge clk); #1;
      if (pending() == 0 && !(busy_s[0] | busy_s[1] | busy_s[2] | busy_s[3])) ok = 1;
    end
    chk("drain", int'(ok), 1);
  endtask

  task automatic burst();
    int c0;
    @(posedge clk); #1;
    c0 = cyc;
    fork
      begin
        for (int i = 0; i < 6; i++) send(0, 9'($urandom_range(0, 255)));
      end
      begin
        wait_cyc(c0 + 5);
        chk("burst_count_full", cnt_s[0], 4);
        chk("burst_ready_full", ready_s[0], 0);
        wait_cyc(c0 + 101);
        chk("burst_count_before_pop", cnt_s[0], 4);
        chk("burst_ready_before_pop", ready_s[0], 0);
        wait_cyc(c0 + 102);
        chk("burst_count_after_pop", cnt_s[0], 3);
        chk("burst_ready_after_pop", ready_s[0], 1);
      end
    join
  endtask

  task automatic reset_test();
    int a;
    send(0, 9'h0F0);
    a = cyc;
    send(0, 9'($urandom_range(0, 255)));
    send(0, 9'($urandom_range(0, 255)));
    wait_cyc(a + 45);
    chk("pre_reset_count", cnt_s[0], 2);
    chk("pre_reset_tx_bit3", tx_s[0], 0);
    #2 rst_n = 1'b0;
    #1;
    chk("midframe_reset_tx", tx_s[0], 1);
    chk("midframe_reset_count", cnt_s[0], 0);
    chk("midframe_reset_ready", ready_s[0], 1);
    chk("midframe_reset_busy", busy_s[0], 0);
    idle(3);
    rst_n = 1'b1;
    idle(150);
    chk("post_reset_tx", tx_s[0], 1);
    chk("post_reset_busy", busy_s[0], 0);
    chk("post_reset_count", cnt_s[0], 0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < NCFG; k++) begin
      valid[k] = 1'b0;
      data[k]  = '0;
    end
    idle(3);
    for (int k = 0; k < NCFG; k++) begin
      chk($sformatf("reset_tx_%0d", k), tx_s[k], 1);
      chk($sformatf("reset_ready_%0d", k), ready_s[k], 1);
      chk($sformatf("reset_busy_%0d", k), busy_s[k], 0);
      chk($sformatf("reset_count_%0d", k), cnt_s[k], 0);
    end
    rst_n = 1'b1;
    idle(20);
    for (int k = 0; k < NCFG; k++) begin
      chk($sformatf("idle_tx_%0d", k), tx_s[k], 1);
      chk($sformatf("idle_busy_%0d", k), busy_s[k], 0);
    end

    // Directed frames: 8N1 0x55, 8E1 0x07, 8O1 0x07, 7N2 0x41.
    send(0, 9'h055);
    send(1, 9'h007);
    send(2, 9'h007);
    send(3, 9'h041);
    wait_drain();

    burst();
    wait_drain();

    // Random words with random spacing on every format.
    for (int k = 0; k < NCFG; k++) begin
      for (int n = 0; n < 8; n++) begin
        if ($urandom_range(0, 3) == 0) idle(130);
        else idle($urandom_range(0, 3));
        send(k, 9'($urandom) & 9'((1 << CFG_DB[k]) - 1));
      end
    end
    wait_drain();

    reset_test();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
